// File: rtl/pc_seq.sv
// pc_seq: program sequencer for the multi-cycle core.
// Owns the PC, the base register and a small return-address stack.
// Fetches one instruction at a time over a req/ack handshake, hands it to the
// decoder over valid/ready, and computes the next PC from jmp_mode on accept.
module pc_seq #(
   parameter int               WIDTH       = 8,
   parameter int               STACK_DEPTH = 4,
   parameter logic [WIDTH-1:0] RST_ADDR    = '0,
   localparam int              LVL_W       = $clog2(STACK_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             soft_rst,
   output logic             rom_req,
   output logic [WIDTH-1:0] rom_addr,
   input  logic             rom_ack,
   input  logic [WIDTH-1:0] rom_instr,
   input  logic [WIDTH-1:0] rom_arg,
   output logic [WIDTH-1:0] instr,
   output logic [WIDTH-1:0] arg,
   output logic             instr_valid,
   input  logic             instr_ready,
   input  logic [2:0]       jmp_mode,
   input  logic [WIDTH-1:0] jmp_addr,
   input  logic [WIDTH-1:0] base_data,
   output logic [WIDTH-1:0] pc,
   output logic [LVL_W-1:0] stack_level,
   output logic             fault
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_ISSUE = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   localparam logic [2:0] OP_NEXT = 3'b000;
   localparam logic [2:0] OP_JMP  = 3'b001;
   localparam logic [2:0] OP_JREL = 3'b010;
   localparam logic [2:0] OP_CALL = 3'b011;
   localparam logic [2:0] OP_RET  = 3'b100;
   localparam logic [2:0] OP_LDB  = 3'b101;

   state_t                            state_q, state_d;
   logic [WIDTH-1:0]                  pc_q, pc_d;
   logic [WIDTH-1:0]                  base_q, base_d;
   logic [LVL_W-1:0]                  lvl_q, lvl_d;
   logic                              fault_q, fault_d;
   logic [WIDTH-1:0]                  instr_q, instr_d;
   logic [WIDTH-1:0]                  arg_q, arg_d;
   logic [STACK_DEPTH-1:0][WIDTH-1:0] stack_q, stack_d;

   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] stack_top;
   logic             stack_full;
   logic             stack_empty;
   logic             accept;

   // Sequential-address helper; the add wraps naturally at 2^WIDTH.
   assign pc_inc      = pc_q + WIDTH'(1);
   assign stack_full  = (lvl_q == LVL_W'(STACK_DEPTH));
   assign stack_empty = (lvl_q == '0);
   assign accept      = (state_q == ST_ISSUE) && instr_ready;

   // Top-of-stack read; a compare loop keeps the level counter (one bit wider
   // than an entry index) from being used directly as an array index.
   always_comb begin
      stack_top = '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
         if (lvl_q == LVL_W'(i + 1)) stack_top = stack_q[i];
      end
   end

   // Next-state, next-PC and stack update; soft_rst overrides everything.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      base_d  = base_q;
      lvl_d   = lvl_q;
      fault_d = fault_q;
      instr_d = instr_q;
      arg_d   = arg_q;
      stack_d = stack_q;

      case (state_q)
         ST_IDLE: begin
            state_d = ST_FETCH;
         end

         ST_FETCH: begin
            if (rom_ack) begin
               instr_d = rom_instr;
               arg_d   = rom_arg;
               state_d = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            if (accept) begin
               state_d = ST_FETCH;
               case (jmp_mode)
                  OP_JMP:  pc_d = jmp_addr;
                  OP_JREL: pc_d = base_q + jmp_addr;
                  OP_CALL: begin
                     if (stack_full) begin
                        // Overflow: nothing pushed, PC frozen for inspection.
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                     end else begin
                        for (int i = 0; i < STACK_DEPTH; i++) begin
                           if (lvl_q == LVL_W'(i)) stack_d[i] = pc_inc;
                        end
                        lvl_d = lvl_q + LVL_W'(1);
                        pc_d  = jmp_addr;
                     end
                  end
                  OP_RET: begin
                     if (stack_empty) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                     end else begin
                        pc_d  = stack_top;
                        lvl_d = lvl_q - LVL_W'(1);
                     end
                  end
                  OP_LDB: begin
                     base_d = base_data;
                     pc_d   = pc_inc;
                  end
                  // NEXT and the unused 11x encodings advance sequentially.
                  default: pc_d = pc_inc;
               endcase
            end
         end

         ST_FAULT: begin
            state_d = ST_FAULT;
         end

         default: state_d = ST_IDLE;
      endcase

      // Restart from the decoder: same values as power-on reset, but go
      // straight to FETCH. Stack contents are dead once the level is zero.
      if (soft_rst) begin
         state_d = ST_FETCH;
         pc_d    = RST_ADDR;
         base_d  = '0;
         lvl_d   = '0;
         fault_d = 1'b0;
         instr_d = '0;
         arg_d   = '0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= RST_ADDR;
         base_q  <= '0;
         lvl_q   <= '0;
         fault_q <= 1'b0;
         instr_q <= '0;
         arg_q   <= '0;
         stack_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         base_q  <= base_d;
         lvl_q   <= lvl_d;
         fault_q <= fault_d;
         instr_q <= instr_d;
         arg_q   <= arg_d;
         stack_q <= stack_d;
      end
   end

   // rom_req is masked by soft_rst so an in-flight fetch is visibly dropped
   // for the restart cycle; any ack arriving then is ignored by the FSM.
   assign rom_req     = (state_q == ST_FETCH) && !soft_rst;
   assign rom_addr    = pc_q;
   assign instr       = instr_q;
   assign arg         = arg_q;
   assign instr_valid = (state_q == ST_ISSUE);
   assign pc          = pc_q;
   assign stack_level = lvl_q;
   assign fault       = fault_q;

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: randomized bench for pc_seq with a queue-based reference model.
// The driver plays instruction memory and decoder; expected fetches and
// instructions are queued on stimulus and checked by an independent monitor.
module tb_pc_seq;
   localparam int         W   = 8;
   localparam int         D   = 4;
   localparam logic [7:0] RA  = 8'h00;

   logic       clk = 1'b0, rst_n = 1'b0, soft_rst = 1'b0;
   logic       rom_ack = 1'b0, instr_ready = 1'b0;
   logic [7:0] rom_instr = '0, rom_arg = '0, jmp_addr = '0, base_data = '0;
   logic [2:0] jmp_mode = '0;
   logic       rom_req, instr_valid, fault;
   logic [7:0] rom_addr, instr, arg, pc;
   logic [2:0] stack_level;

   pc_seq #(.WIDTH(W), .STACK_DEPTH(D), .RST_ADDR(RA)) dut (
      .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst),
      .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack),
      .rom_instr(rom_instr), .rom_arg(rom_arg),
      .instr(instr), .arg(arg), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .jmp_mode(jmp_mode), .jmp_addr(jmp_addr), .base_data(base_data),
      .pc(pc), .stack_level(stack_level), .fault(fault)
   );

   always #5 clk = ~clk;

   typedef struct { logic flt; logic [7:0] addr; int lvl; } ev_t;
   typedef struct { logic [2:0] m; logic [7:0] a; logic [7:0] b; } op_t;

   ev_t         ev_q[$];     // expected next fetch (or fault) events
   logic [15:0] ins_q[$];    // expected {instr,arg} latched by the DUT
   op_t         dir_q[$];    // directed decoder operations
   int          checks = 0, errors = 0;

   // Reference model: plain PC/base values and a queue as the stack.
   logic [7:0] m_pc, m_base;
   logic [7:0] m_stk[$];
   bit         m_fault;

   // Knobs set by the control process.
   bit ack_always = 1, ready_always = 1, rand_mode = 0, rand_delay = 0;
   bit rand_srst = 0, chk_thru = 0, chk_len = 0;
   int fix_delay = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_pc = RA; m_base = '0; m_stk.delete(); m_fault = 0;
      ev_q.delete();
      ev_q.push_back('{1'b0, RA, 0});
   endfunction

   function automatic void model_accept(logic [2:0] m, logic [7:0] a, logic [7:0] b);
      logic [7:0] inc, nxt;
      bit err;
      err = 0;
      inc = m_pc + 8'd1;
      nxt = inc;
      case (m)
         3'd1: nxt = a;
         3'd2: nxt = m_base + a;
         3'd3: if (m_stk.size() == D) err = 1; else begin m_stk.push_back(inc); nxt = a; end
         3'd4: if (m_stk.size() == 0) err = 1; else nxt = m_stk.pop_back();
         3'd5: m_base = b;
         default: ;
      endcase
      if (err) begin
         m_fault = 1;
         ev_q.push_back('{1'b1, m_pc, m_stk.size()});
      end else begin
         m_pc = nxt;
         ev_q.push_back('{1'b0, m_pc, m_stk.size()});
      end
   endfunction

   // Driver: memory and decoder behaviour, one decision per cycle.
   int  cnt, cur_d, flt_cnt = 0;
   bit  in_fetch = 0, acc_prev = 0, srst_prev = 0;
   initial begin
      op_t op;
      bit  req_now, iv_now, do_srst, acc;
      wait (rst_n);
      forever begin
         @(posedge clk);
         #1 soft_rst = 1'b0;
         #1;
         req_now = rom_req;
         iv_now  = instr_valid;
         do_srst = 0;
         if (m_fault) begin
            flt_cnt++;
            if (flt_cnt >= 3) do_srst = 1;
         end else flt_cnt = 0;
         if (!do_srst && rand_srst && !acc_prev && !srst_prev && $urandom_range(0, 59) == 0)
            do_srst = 1;
         rom_instr = 8'($urandom);
         rom_arg   = 8'($urandom);
         if (do_srst) begin
            soft_rst    = 1'b1;
            rom_ack     = m_fault ? 1'b1 : 1'($urandom);
            instr_ready = 1'($urandom);
            jmp_mode    = 3'($urandom);
            model_reset();
            in_fetch  = 0;
            acc_prev  = 0;
            srst_prev = 1;
         end else begin
            if (req_now) begin
               if (!in_fetch) begin
                  in_fetch = 1; cnt = 0;
                  cur_d = ack_always ? 0 : (rand_delay ? int'($urandom_range(0, 4)) : fix_delay);
               end
               if (cnt == cur_d) begin
                  rom_ack = 1'b1;
                  ins_q.push_back({rom_instr, rom_arg});
                  in_fetch = 0;
               end else begin
                  rom_ack = 1'b0;
                  cnt++;
               end
            end else begin
               rom_ack = ack_always ? 1'b1 : ($urandom_range(0, 3) == 0);
            end
            acc = 0;
            if (iv_now) instr_ready = ready_always || ($urandom_range(0, 2) != 0);
            else        instr_ready = 1'($urandom);
            if (iv_now && instr_ready && dir_q.size() != 0) op = dir_q.pop_front();
            else begin
               op.m = rand_mode ? 3'($urandom_range(0, 7)) : 3'd0;
               op.a = 8'($urandom);
               op.b = 8'($urandom);
            end
            jmp_mode  = op.m;
            jmp_addr  = op.a;
            base_data = op.b;
            if (iv_now && instr_ready) begin
               model_accept(op.m, op.a, op.b);
               acc = 1;
            end
            acc_prev  = acc;
            srst_prev = 0;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents a fetch, a fault
   // or a new instruction, sampled on the falling edge.
   int          cyc = 0, last_f = -1, req_len = 0, idle = 0, nfetch = 0;
   logic [7:0]  cur_addr = '0;
   logic [15:0] cur_ins = '0;
   logic        prev_req = 0, prev_flt = 0, prev_iv = 0;
   always @(negedge clk) begin
      ev_t e;
      if (rst_n) begin
         cyc++;
         idle++;
         if (rom_req && !prev_req) begin
            chk("fetch_expected", ev_q.size() != 0, 1);
            if (ev_q.size() != 0) begin
               e = ev_q.pop_front();
               chk("fetch_kind", e.flt, 0);
               chk("fetch_addr", rom_addr, e.addr);
               chk("fetch_pc", pc, e.addr);
               chk("fetch_lvl", stack_level, e.lvl);
               chk("fetch_nofault", fault, 0);
            end
            if (chk_thru && last_f >= 0) chk("cycles_per_instr", cyc - last_f, 2);
            last_f = cyc; cur_addr = rom_addr; req_len = 0; idle = 0; nfetch++;
         end
         if (rom_req) begin
            req_len++;
            chk("addr_stable", rom_addr, cur_addr);
         end
         if (!rom_req && prev_req && !soft_rst && chk_len)
            chk("req_len", req_len, fix_delay + 1);
         if (fault && !prev_flt) begin
            chk("fault_expected", ev_q.size() != 0, 1);
            if (ev_q.size() != 0) begin
               e = ev_q.pop_front();
               chk("fault_kind", e.flt, 1);
               chk("fault_pc_held", pc, e.addr);
               chk("fault_lvl", stack_level, e.lvl);
            end
            idle = 0;
         end
         if (fault) chk("fault_quiet", {rom_req, instr_valid}, 0);
         if (instr_valid && !prev_iv) begin
            chk("instr_expected", ins_q.size() != 0, 1);
            if (ins_q.size() != 0) begin
               cur_ins = ins_q.pop_front();
               chk("instr_arg", {instr, arg}, cur_ins);
            end
         end
         if (instr_valid) chk("instr_stable", {instr, arg}, cur_ins);
         if (soft_rst) chk("srst_req_drop", rom_req, 0);
         if (idle > 60) begin
            chk("watchdog_progress", idle, 0);
            idle = 0;
         end
         prev_req = rom_req; prev_flt = fault; prev_iv = instr_valid;
      end
   end

   task automatic wait_dir(input int maxc);
      int n = 0;
      while (dir_q.size() != 0 && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk("directed_drain", dir_q.size(), 0);
   endtask

   // Control: reset checks and test phases.
   initial begin
      model_reset();
      #15;
      chk("rst_pc", pc, RA);
      chk("rst_req", rom_req, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_fault", fault, 0);
      chk("rst_level", stack_level, 0);
      chk("rst_instr_arg", {instr, arg}, 0);
      #7 rst_n = 1'b1;

      // Back-to-back NEXT with immediate ack/ready, long enough to wrap PC.
      repeat (10) @(negedge clk);
      chk_thru = 1;
      repeat (530) @(negedge clk);
      chk_thru = 0;

      // Slow memory (3-cycle ack delay) with directed control flow.
      ack_always = 0; fix_delay = 3;
      dir_q.push_back('{3'd1, 8'h05, 8'h00});   // JMP 0x05
      dir_q.push_back('{3'd0, 8'h00, 8'h00});   // NEXT
      dir_q.push_back('{3'd5, 8'h00, 8'hF0});   // LDB 0xF0
      dir_q.push_back('{3'd2, 8'h20, 8'h00});   // JREL 0x20 -> 0x10
      dir_q.push_back('{3'd3, 8'h40, 8'h00});   // CALL 0x40
      dir_q.push_back('{3'd3, 8'h80, 8'h00});   // CALL 0x80
      dir_q.push_back('{3'd4, 8'h00, 8'h00});   // RET -> 0x81? no: 0x41
      dir_q.push_back('{3'd4, 8'h00, 8'h00});   // RET -> 0x11
      for (int i = 0; i < 5; i++)               // fifth nested CALL overflows
         dir_q.push_back('{3'd3, 8'(8'h10 * (i + 1)), 8'h00});
      repeat (5) @(negedge clk);
      chk_len = 1;
      wait_dir(400);
      repeat (30) @(negedge clk);

      dir_q.push_back('{3'd4, 8'h00, 8'h00});   // RET at level 0 underflows
      wait_dir(100);
      repeat (30) @(negedge clk);
      chk_len = 0;

      // Fully randomized traffic, including random restarts.
      rand_delay = 1; rand_mode = 1; ready_always = 0; rand_srst = 1;
      repeat (3000) @(negedge clk);
      rand_srst = 0; rand_mode = 0; ready_always = 1;
      repeat (40) @(negedge clk);
      chk("progress", nfetch > 500, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
